// File: rtl/frame_buffer_dbl_if.sv
// Bus bundle for the double-buffered frame store: pixel input stream,
// page control, front-page read port and status flags.
interface frame_buffer_dbl_if #(
    parameter int P_DATA_W = 24,
    parameter int P_ADDR_W = 17
);
    // Valid-only stream, no ready: a pixel is offered when piul1WrValid is high
    // and is taken or dropped in that same cycle; poul1WrBusy and poul1FrameReady
    // tell the producer when offered pixels will be dropped.
    logic                piul1WrValid;
    logic                piul1WrSof;
    logic [P_DATA_W-1:0] piulWrData;
    logic                piul1Clear;
    logic [P_DATA_W-1:0] piulClearColor;
    logic                piul1SwapReq;
    logic                piul1RdEnable;
    logic [P_ADDR_W-1:0] piulRdAddr;
    logic [P_DATA_W-1:0] poulRdData;
    logic                poul1RdValid;
    logic                poul1FrontPage;
    logic                poul1FrameReady;
    logic                poul1WrBusy;
    logic                poul1WrError;
    logic [1:0]          poulDbgState;

    modport master (
        output piul1WrValid, piul1WrSof, piulWrData, piul1Clear, piulClearColor,
               piul1SwapReq, piul1RdEnable, piulRdAddr,
        input  poulRdData, poul1RdValid, poul1FrontPage, poul1FrameReady,
               poul1WrBusy, poul1WrError, poulDbgState
    );

    modport slave (
        input  piul1WrValid, piul1WrSof, piulWrData, piul1Clear, piulClearColor,
               piul1SwapReq, piul1RdEnable, piulRdAddr,
        output poulRdData, poul1RdValid, poul1FrontPage, poul1FrameReady,
               poul1WrBusy, poul1WrError, poulDbgState
    );
endinterface

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame store: a raster stream fills the back page, the display
// reads the front page, and pages swap only once a whole frame is present.
module frame_buffer_dbl #(
    parameter int P_WIDTH  = 320,
    parameter int P_HEIGHT = 240,
    parameter int P_DATA_W = 24,
    parameter int P_ADDR_W = 17
) (
    input  logic              piul1Clock,
    input  logic              piul1Reset_n,
    frame_buffer_dbl_if.slave bus
);
    localparam int N  = P_WIDTH * P_HEIGHT;
    localparam int IW = $clog2(2 * N);
    localparam logic [P_ADDR_W:0] C_N    = (P_ADDR_W + 1)'(N);
    localparam logic [P_ADDR_W:0] C_LAST = (P_ADDR_W + 1)'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DONE  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [P_ADDR_W:0]   cnt_q, cnt_d;
    logic                front_q, front_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                wr_en;
    logic [P_ADDR_W:0]   wr_off;
    logic [P_DATA_W-1:0] wr_data;
    logic [IW-1:0]       wr_idx, rd_idx;
    logic [P_DATA_W-1:0] rd_data_q;
    logic                rd_valid_q;
    logic                rd_in_range;

    logic [P_DATA_W-1:0] mem [0:2*N-1];

    always_ff @(posedge piul1Clock) begin
        if (!piul1Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            front_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            front_q <= front_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        front_d = front_q;
        ready_d = ready_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_off  = cnt_q;
        wr_data = bus.piulWrData;
        unique case (state_q)
            S_IDLE: begin
                if (bus.piul1Clear) begin
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end else if (bus.piul1WrValid && bus.piul1WrSof) begin
                    wr_en   = 1'b1;
                    wr_off  = '0;
                    cnt_d   = (P_ADDR_W + 1)'(1);
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.piul1Clear) begin
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end else if (bus.piul1WrValid && bus.piul1WrSof) begin
                    // Short frame: restart from the new start-of-frame.
                    err_d  = 1'b1;
                    wr_en  = 1'b1;
                    wr_off = '0;
                    cnt_d  = (P_ADDR_W + 1)'(1);
                end else if (bus.piul1WrValid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        ready_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.piul1WrValid) err_d = 1'b1;
                if (bus.piul1SwapReq) begin
                    front_d = ~front_q;
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.piul1Clear) begin
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_data = bus.piulClearColor;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Back page occupies the upper half of the RAM when page 0 is displayed.
    assign wr_idx      = IW'(wr_off) + (front_q ? '0 : IW'(N));
    assign rd_in_range = {1'b0, bus.piulRdAddr} < C_N;
    assign rd_idx      = IW'(bus.piulRdAddr) + (front_q ? IW'(N) : '0);

    always_ff @(posedge piul1Clock) begin
        if (piul1Reset_n && wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge piul1Clock) begin
        if (!piul1Reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.piul1RdEnable;
            if (bus.piul1RdEnable) rd_data_q <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

    assign bus.poulRdData      = rd_data_q;
    assign bus.poul1RdValid    = rd_valid_q;
    assign bus.poul1FrontPage  = front_q;
    assign bus.poul1FrameReady = ready_q;
    assign bus.poul1WrBusy     = (state_q == S_CLEAR);
    assign bus.poul1WrError    = err_q;
    assign bus.poulDbgState    = state_q;
endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Bench for frame_buffer_dbl (4x2 frame, 8-bit pixels): directed scenarios with
// literal expectations plus randomized traffic checked against a page-array model.
module tb_frame_buffer_dbl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    frame_buffer_dbl_if #(.P_DATA_W(DW), .P_ADDR_W(AW)) bus ();

    frame_buffer_dbl #(.P_WIDTH(4), .P_HEIGHT(2), .P_DATA_W(DW), .P_ADDR_W(AW)) dut (
        .piul1Clock  (clk),
        .piul1Reset_n(rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [2][NP];
    bit            m_known [2][NP];
    bit            m_front, m_ready, m_filling, m_err, m_rd_valid, m_rd_known, live;
    int            m_count, m_clear_left;
    logic [DW-1:0] m_rd_data;

    initial begin
        live = 0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NP; i++) m_known[p][i] = 0;
    end

    always @(posedge clk) begin
        int back;
        if (!rst_n) begin
            m_front = 0; m_ready = 0; m_filling = 0; m_err = 0;
            m_count = 0; m_clear_left = 0;
            m_rd_valid = 0; m_rd_data = '0; m_rd_known = 1;
            live = 1;
        end else begin
            m_rd_valid = bus.piul1RdEnable;
            if (bus.piul1RdEnable) begin
                if (int'(bus.piulRdAddr) < NP) begin
                    m_rd_data  = m_mem[int'(m_front)][int'(bus.piulRdAddr)];
                    m_rd_known = m_known[int'(m_front)][int'(bus.piulRdAddr)];
                end else begin
                    m_rd_data  = '0;
                    m_rd_known = 1;
                end
            end
            back = m_front ? 0 : 1;
            if (m_clear_left > 0) begin
                m_mem[back][NP - m_clear_left]   = bus.piulClearColor;
                m_known[back][NP - m_clear_left] = 1;
                m_clear_left--;
                if (m_clear_left == 0) m_ready = 1;
            end else if (m_ready) begin
                if (bus.piul1WrValid) m_err = 1;
                if (bus.piul1SwapReq) begin
                    m_front = !m_front;
                    m_ready = 0;
                end else if (bus.piul1Clear) begin
                    m_ready = 0;
                    m_clear_left = NP;
                end
            end else if (bus.piul1Clear) begin
                m_filling = 0;
                m_clear_left = NP;
            end else if (bus.piul1WrValid && bus.piul1WrSof) begin
                if (m_filling) m_err = 1;
                m_mem[back][0] = bus.piulWrData;
                m_known[back][0] = 1;
                m_count = 1;
                m_filling = 1;
            end else if (bus.piul1WrValid && m_filling) begin
                m_mem[back][m_count] = bus.piulWrData;
                m_known[back][m_count] = 1;
                m_count++;
                if (m_count == NP) begin
                    m_filling = 0;
                    m_ready = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("m_rd_valid", 32'(bus.poul1RdValid), 32'(m_rd_valid));
            if (m_rd_known) chk("m_rd_data", 32'(bus.poulRdData), 32'(m_rd_data));
            chk("m_front", 32'(bus.poul1FrontPage), 32'(m_front));
            chk("m_ready", 32'(bus.poul1FrameReady), 32'(m_ready));
            chk("m_busy", 32'(bus.poul1WrBusy), 32'(m_clear_left > 0));
            chk("m_err", 32'(bus.poul1WrError), 32'(m_err));
            chk("m_state", 32'(bus.poulDbgState),
                (m_clear_left > 0) ? 32'd3 : m_ready ? 32'd2 : m_filling ? 32'd1 : 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.piul1WrValid = 0; bus.piul1WrSof = 0; bus.piulWrData = '0;
        bus.piul1Clear = 0; bus.piulClearColor = '0; bus.piul1SwapReq = 0;
        bus.piul1RdEnable = 0; bus.piulRdAddr = '0;
    endtask

    task automatic send_pix(input logic [DW-1:0] d, input bit sof);
        bus.piul1WrValid = 1; bus.piul1WrSof = sof; bus.piulWrData = d;
        cyc();
        bus.piul1WrValid = 0; bus.piul1WrSof = 0;
    endtask

    task automatic swap();
        bus.piul1SwapReq = 1;
        cyc();
        bus.piul1SwapReq = 0;
    endtask

    task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.piul1RdEnable = 1; bus.piulRdAddr = a;
        cyc();
        bus.piul1RdEnable = 0;
        chk("lit_rd_valid", 32'(bus.poul1RdValid), 32'd1);
        chk("lit_rd_data", 32'(bus.poulRdData), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_front", 32'(bus.poul1FrontPage), 32'd0);
        chk("rst_ready", 32'(bus.poul1FrameReady), 32'd0);
        chk("rst_busy", 32'(bus.poul1WrBusy), 32'd0);
        chk("rst_err", 32'(bus.poul1WrError), 32'd0);
        chk("rst_rd_valid", 32'(bus.poul1RdValid), 32'd0);
        chk("rst_rd_data", 32'(bus.poulRdData), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_cycles;
        idle_inputs();
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
        chk_reset_vals();

        // Basic fill and swap
        for (int i = 0; i < NP; i++) send_pix(8'h10 + 8'(i), i == 0);
        chk("fill_ready", 32'(bus.poul1FrameReady), 32'd1);
        swap();
        chk("swap_front", 32'(bus.poul1FrontPage), 32'd1);
        chk("swap_ready", 32'(bus.poul1FrameReady), 32'd0);
        for (int i = 0; i < NP; i++) read_check(AW'(i), 8'h10 + 8'(i));

        // No tear: write next frame while reading the displayed one
        for (int i = 0; i < NP; i++) begin
            bus.piul1WrValid = 1; bus.piul1WrSof = (i == 0); bus.piulWrData = 8'h20 + 8'(i);
            bus.piul1RdEnable = 1; bus.piulRdAddr = AW'(NP - 1 - i);
            cyc();
            chk("tear_rd_data", 32'(bus.poulRdData), 32'(8'h17 - 8'(i)));
        end
        idle_inputs();
        read_check(4'd3, 8'h13);
        swap();
        chk("swap2_front", 32'(bus.poul1FrontPage), 32'd0);
        for (int i = 0; i < NP; i++) read_check(AW'(i), 8'h20 + 8'(i));

        // Short frame then a full one
        for (int i = 0; i < 3; i++) send_pix(8'h50 + 8'(i), i == 0);
        for (int i = 0; i < NP; i++) send_pix(8'h30 + 8'(i), i == 0);
        chk("short_err", 32'(bus.poul1WrError), 32'd1);
        chk("short_ready", 32'(bus.poul1FrameReady), 32'd1);
        swap();
        for (int i = 0; i < NP; i++) read_check(AW'(i), 8'h30 + 8'(i));

        // Clear from a fresh reset: pixels during CLEAR dropped without error
        do_reset();
        chk_reset_vals();
        bus.piul1Clear = 1; bus.piulClearColor = 8'hAA;
        cyc();
        bus.piul1Clear = 0;
        busy_cycles = 0;
        while (bus.poul1WrBusy && busy_cycles < 20) begin
            bus.piul1WrValid = 1; bus.piul1WrSof = (busy_cycles == 2); bus.piulWrData = 8'h99;
            cyc();
            busy_cycles++;
        end
        idle_inputs();
        chk("clear_busy_cycles", 32'(busy_cycles), 32'd8);
        chk("clear_err", 32'(bus.poul1WrError), 32'd0);
        chk("clear_ready", 32'(bus.poul1FrameReady), 32'd1);
        swap();
        chk("clear_front", 32'(bus.poul1FrontPage), 32'd1);
        for (int i = 0; i < NP; i++) read_check(AW'(i), 8'hAA);

        // Ignored swap during FILL, overrun in DONE
        for (int i = 0; i < 4; i++) send_pix(8'h40 + 8'(i), i == 0);
        swap();
        chk("ign_swap_front", 32'(bus.poul1FrontPage), 32'd1);
        for (int i = 4; i < NP; i++) send_pix(8'h40 + 8'(i), 1'b0);
        chk("ovr_ready", 32'(bus.poul1FrameReady), 32'd1);
        send_pix(8'hEE, 1'b0);
        chk("ovr_err", 32'(bus.poul1WrError), 32'd1);
        swap();
        chk("ovr_front", 32'(bus.poul1FrontPage), 32'd0);
        for (int i = 0; i < NP; i++) read_check(AW'(i), 8'h40 + 8'(i));

        // Reset mid-FILL, then out-of-range read
        read_check(4'd2, 8'h42);
        for (int i = 0; i < 3; i++) send_pix(8'h60 + 8'(i), i == 0);
        do_reset();
        chk_reset_vals();
        read_check(4'd8, 8'h00);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n              = ($urandom_range(0, 499) != 0);
            bus.piul1WrValid   = ($urandom_range(0, 9) < 7);
            bus.piul1WrSof     = ($urandom_range(0, 19) == 0);
            bus.piulWrData     = DW'($urandom);
            bus.piul1Clear     = ($urandom_range(0, 99) == 0);
            bus.piulClearColor = DW'($urandom);
            bus.piul1SwapReq   = ($urandom_range(0, 9) == 0);
            bus.piul1RdEnable  = ($urandom_range(0, 1) == 1);
            bus.piulRdAddr     = AW'($urandom_range(0, 9));
            cyc();
        end
        rst_n = 1;
        idle_inputs();
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
